// File: rtl/bsg_one_fifo_rr_arb.sv
// Round-robin arbiter feeding a one-element buffer. Requesters compete for the
// single staging register; the winner's word is captured with its index as tag.
module bsg_one_fifo_rr_arb #(
    parameter int unsigned width_p      = 32,
    parameter int unsigned els_p        = 4,
    localparam int unsigned tag_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   data_i,
    output logic [els_p-1:0]           ready_o,

    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic [tag_width_lp-1:0]    tag_o,
    input  logic                       yumi_i
);

    localparam logic [tag_width_lp-1:0] LastReset = tag_width_lp'(els_p - 1);

    logic                    full_r;
    logic [width_p-1:0]      data_r;
    logic [tag_width_lp-1:0] tag_r;
    logic [tag_width_lp-1:0] last_r;

    logic                    found;
    logic                    accept;
    int unsigned             idx;
    int unsigned             win_idx;
    logic [width_p-1:0]      win_data;

    // Scan from last_r+1 with wrap at els_p; the first valid requester wins.
    always_comb begin
        found    = 1'b0;
        idx      = 0;
        win_idx  = 0;
        win_data = '0;
        ready_o  = '0;
        for (int unsigned k = 1; k <= els_p; k++) begin
            idx = (int'(last_r) + k) % els_p;
            if (!found && v_i[idx]) begin
                found    = 1'b1;
                win_idx  = idx;
                win_data = data_i[idx*width_p +: width_p];
            end
        end
        // Grant only into an empty buffer; yumi never enables a same-cycle refill.
        if (!full_r && found) begin
            ready_o[win_idx] = 1'b1;
        end
    end

    assign accept = !full_r && found;

    // Full flag and fairness pointer; the pointer moves only on an accepted word.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_r <= 1'b0;
            last_r <= LastReset;
        end else if (accept) begin
            full_r <= 1'b1;
            last_r <= tag_width_lp'(win_idx);
        end else if (full_r && yumi_i) begin
            full_r <= 1'b0;
        end
    end

    // Payload register: no reset, contents are meaningless while v_o is low.
    always_ff @(posedge clk_i) begin
        if (!reset_i && accept) begin
            data_r <= win_data;
            tag_r  <= tag_width_lp'(win_idx);
        end
    end

    assign v_o    = full_r;
    assign data_o = data_r;
    assign tag_o  = tag_r;

endmodule

// File: tb/tb_bsg_one_fifo_rr_arb.sv
// Directed bench for bsg_one_fifo_rr_arb: stimulus pushes expected {data, tag}
// words into a queue; a monitor pops one per output word and compares.
module tb_bsg_one_fifo_rr_arb;

    localparam int unsigned W = 32;
    localparam int unsigned N = 4;
    localparam int unsigned T = 2;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [N-1:0]     v_i;
    logic [N*W-1:0]   data_i;
    logic [N-1:0]     ready_o;
    logic             v_o;
    logic [W-1:0]     data_o;
    logic [T-1:0]     tag_o;
    logic             yumi_i;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W+T-1:0] exp_q[$];
    logic           seen = 1'b0;

    bsg_one_fifo_rr_arb #(.width_p(W), .els_p(N)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .tag_o   (tag_o),
        .yumi_i  (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [W-1:0] val);
        data_i[i*W +: W] = val;
    endtask

    function automatic logic [W-1:0] slot(input int i);
        return data_i[i*W +: W];
    endfunction

    task automatic push(input int i);
        exp_q.push_back({slot(i), T'(i)});
    endtask

    // Monitor: one pop per word, on the first cycle v_o is seen high.
    always @(negedge clk_i) begin
        logic [W+T-1:0] e;
        if (yumi_i) chk("yumi_only_when_valid", 32'(v_o), 32'd1);
        if (v_o && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("word_data", data_o, e[W+T-1:T]);
                chk("word_tag", 32'(tag_o), 32'(e[T-1:0]));
            end
        end
        if (!v_o) seen = 1'b0;
    end

    initial begin
        logic [N-1:0] seq [6];
        reset_i = 1'b1;
        v_i     = 4'b1111;
        yumi_i  = 1'b0;
        for (int i = 0; i < 4; i++) set_slot(i, 32'hA000_0000 + 32'(i));

        // 1. Reset with all requesters valid.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            chk("reset_v_o", 32'(v_o), 32'd0);
            chk("reset_ready", 32'(ready_o), 32'h1);
            step();
        end
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("post_reset_ready", 32'(ready_o), 32'h1);
        push(0);
        step();
        v_i = 4'b0000;
        yumi_i = 1'b1;
        @(negedge clk_i);
        chk("first_v_o", 32'(v_o), 32'd1);
        step();
        yumi_i = 1'b0;

        // 2. Single requester 2, yumi whenever valid: one word every two cycles.
        set_slot(2, 32'hDEAD_BEEF);
        v_i = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            yumi_i = v_o;
            @(negedge clk_i);
            chk("single_v_o", 32'(v_o), 32'(k % 2));
            chk("single_ready", 32'(ready_o), (k % 2 == 0) ? 32'h4 : 32'h0);
            if (k % 2 == 0) push(2);
            step();
        end
        yumi_i = 1'b0;

        // 3. Fairness: pointer at 2, all valid -> grants 3,0,1,2,3,0.
        for (int i = 0; i < 4; i++) set_slot(i, 32'hB000_0010 * 32'(i + 1));
        seq[0] = 4'b1000; seq[1] = 4'b0001; seq[2] = 4'b0010;
        seq[3] = 4'b0100; seq[4] = 4'b1000; seq[5] = 4'b0001;
        v_i = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            yumi_i = v_o;
            @(negedge clk_i);
            if (k % 2 == 0) begin
                chk("fair_ready", 32'(ready_o), 32'(seq[k/2]));
                case (seq[k/2])
                    4'b0001: push(0);
                    4'b0010: push(1);
                    4'b0100: push(2);
                    default: push(3);
                endcase
            end else begin
                chk("fair_ready_full", 32'(ready_o), 32'h0);
            end
            step();
        end
        yumi_i = 1'b0;

        // 4. Accept from 1, then 0011 -> grant 0 (wrapping past 2,3), then 1.
        v_i = 4'b0010;
        @(negedge clk_i);
        chk("gap_ready1", 32'(ready_o), 32'h2);
        push(1);
        step();
        v_i = 4'b0011;
        yumi_i = 1'b1;
        @(negedge clk_i);
        chk("gap_full_ready", 32'(ready_o), 32'h0);
        step();
        yumi_i = 1'b0;
        @(negedge clk_i);
        chk("gap_wrap_ready0", 32'(ready_o), 32'h1);
        push(0);
        step();
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        @(negedge clk_i);
        chk("gap_then_ready1", 32'(ready_o), 32'h2);
        push(1);
        step();
        yumi_i = 1'b1;
        step();
        v_i = 4'b0000;
        yumi_i = 1'b0;

        // 5. Backpressure while holding tag 3; inputs change underneath.
        v_i = 4'b1000;
        set_slot(3, 32'h3333_3333);
        @(negedge clk_i);
        chk("bp_ready3", 32'(ready_o), 32'h8);
        push(3);
        step();
        v_i = 4'b1111;
        set_slot(3, 32'h9999_9999);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            chk("bp_v_o", 32'(v_o), 32'd1);
            chk("bp_ready", 32'(ready_o), 32'h0);
            chk("bp_data", data_o, 32'h3333_3333);
            chk("bp_tag", 32'(tag_o), 32'd3);
            step();
        end
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        @(negedge clk_i);
        chk("bp_after_ready0", 32'(ready_o), 32'h1);
        push(0);
        step();
        yumi_i = 1'b1;
        step();
        v_i = 4'b0000;
        yumi_i = 1'b0;

        // 6. Reset while full with tag 2; pointer returns to 3.
        v_i = 4'b0100;
        @(negedge clk_i);
        chk("rst_full_ready2", 32'(ready_o), 32'h4);
        push(2);
        step();
        reset_i = 1'b1;
        v_i = 4'b1100;
        @(negedge clk_i);
        chk("rst_full_v_o", 32'(v_o), 32'd1);
        step();
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_drop_v_o", 32'(v_o), 32'd0);
        chk("rst_ptr_ready", 32'(ready_o), 32'h4);
        push(2);
        step();
        yumi_i = 1'b1;
        step();
        v_i = 4'b0000;
        yumi_i = 1'b0;
        step();
        step();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
